// File: rtl/rv_buffered_interface_pkg.sv
// -----------------------------------------------------------------------------
// rv_buffered_if_pkg
// Shared helpers for the buffered ready-valid device interface:
//   ptr_width()      - FIFO pointer width for a given depth (log2(depth))
//   cnt_width()      - FIFO occupancy counter width (log2(depth)+1)
//   depth_is_legal() - depth must be a power of two and at least 2
// No ports (package).
// -----------------------------------------------------------------------------
package rv_buffered_if_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32'd8;
    localparam int unsigned DEFAULT_DEPTH = 32'd4;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 32'd1;
    endfunction

    function automatic bit depth_is_legal(input int unsigned depth);
        return (depth >= 32'd2) && ((depth & (depth - 32'd1)) == 32'd0);
    endfunction

    // Depth legality of the default configuration, usable as a static check.
    localparam bit DEFAULT_DEPTH_LEGAL = depth_is_legal(DEFAULT_DEPTH);

endpackage

// File: rtl/rv_buffered_interface_if.sv
// -----------------------------------------------------------------------------
// rv_buffered_interface_if
// Bundles the system-side ready-valid bus and the device-side handshake of
// rv_buffered_interface.
//   slave  modport : view of the buffered interface block itself
//   master modport : view of the surrounding system/device (testbench)
// Optional status signals (WRITE_LEVEL_O, READ_LEVEL_O, OVERFLOW_O) exist only
// when RV_BUFFERED_IF_STATUS_EN is defined.
// -----------------------------------------------------------------------------
interface rv_buffered_interface_if #(
    parameter int unsigned WRITE_WIDTH = 32'd8,
    parameter int unsigned READ_WIDTH  = 32'd8
`ifdef RV_BUFFERED_IF_STATUS_EN
    ,
    parameter int unsigned WRITE_DEPTH = 32'd4,
    parameter int unsigned READ_DEPTH  = 32'd4
`endif
);
    // System side
    logic                   READ_READY_I;
    logic                   READ_VALID_O;
    logic [READ_WIDTH-1:0]  READ_DATA_O;
    logic                   WRITE_READY_O;
    logic                   WRITE_VALID_I;
    logic [WRITE_WIDTH-1:0] WRITE_DATA_I;
    // Device side
    logic                   READ_ENABLE_I;
    logic                   WRITE_ENABLE_I;
    logic                   UPDATE_O;
    logic [WRITE_WIDTH-1:0] DATA_O;
    logic                   DEV_READY_I;
    logic                   CHANGE_I;
    logic [READ_WIDTH-1:0]  DATA_I;
    logic                   READ_O;
`ifdef RV_BUFFERED_IF_STATUS_EN
    logic [rv_buffered_if_pkg::cnt_width(WRITE_DEPTH)-1:0] WRITE_LEVEL_O;
    logic [rv_buffered_if_pkg::cnt_width(READ_DEPTH)-1:0]  READ_LEVEL_O;
    logic                                                  OVERFLOW_O;
`endif

    modport slave (
        input  READ_READY_I, WRITE_VALID_I, WRITE_DATA_I,
        input  READ_ENABLE_I, WRITE_ENABLE_I, DEV_READY_I, CHANGE_I, DATA_I,
        output READ_VALID_O, READ_DATA_O, WRITE_READY_O,
`ifdef RV_BUFFERED_IF_STATUS_EN
        output WRITE_LEVEL_O, READ_LEVEL_O, OVERFLOW_O,
`endif
        output UPDATE_O, DATA_O, READ_O
    );

    modport master (
        output READ_READY_I, WRITE_VALID_I, WRITE_DATA_I,
        output READ_ENABLE_I, WRITE_ENABLE_I, DEV_READY_I, CHANGE_I, DATA_I,
        input  READ_VALID_O, READ_DATA_O, WRITE_READY_O,
`ifdef RV_BUFFERED_IF_STATUS_EN
        input  WRITE_LEVEL_O, READ_LEVEL_O, OVERFLOW_O,
`endif
        input  UPDATE_O, DATA_O, READ_O
    );

endinterface

// File: rtl/rv_buffered_interface_fifo.sv
// -----------------------------------------------------------------------------
// rv_sync_fifo
// Single-clock FIFO, no bypass: a word pushed in cycle n is visible at head_s
// from cycle n+1. Storage, pointers and count clear on asynchronous RST_I.
// Ports:
//   CLK_I, RST_I   clock (rising edge), asynchronous active-high reset
//   push_s         write push_data_s (ignored while full)
//   push_data_s    word to store
//   pop_s          drop the head word (ignored while empty)
//   full_s         registered count == DEPTH (a same-cycle pop frees nothing)
//   empty_s        registered count == 0
//   head_s         oldest stored word
//   count_s        occupancy, only with RV_BUFFERED_IF_STATUS_EN
// -----------------------------------------------------------------------------
module rv_sync_fifo
    import rv_buffered_if_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd8,
    parameter int unsigned DEPTH = 32'd4
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             push_s,
    input  logic [WIDTH-1:0] push_data_s,
    input  logic             pop_s,
    output logic             full_s,
    output logic             empty_s,
    output logic [WIDTH-1:0] head_s
`ifdef RV_BUFFERED_IF_STATUS_EN
    ,
    output logic [cnt_width(DEPTH)-1:0] count_s
`endif
);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags, guarded push/pop and head word.
    always_comb begin
        full_s    = (count_r == CW'(DEPTH));
        empty_s   = (count_r == {CW{1'b0}});
        do_push_s = push_s & ~full_s;
        do_pop_s  = pop_s & ~empty_s;
        head_s    = mem_r[rd_ptr_r];
    end

`ifdef RV_BUFFERED_IF_STATUS_EN
    // Occupancy is exported only for the status outputs.
    always_comb begin
        count_s = count_r;
    end
`endif

    // Storage, pointers (wrap modulo DEPTH) and occupancy counter.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            for (int unsigned i = 32'd0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rv_buffered_interface.sv
// -----------------------------------------------------------------------------
// rv_buffered_interface
// Buffered ready-valid device interface. A write FIFO carries system words to
// the device (drained by DEV_READY_I); a read FIFO captures device data on
// CHANGE_I or, when empty, on a polled read.
// Ports:
//   CLK_I, RST_I  clock (rising edge), asynchronous active-high reset
//   bus           rv_buffered_interface_if.slave: system RV bus, device
//                 handshake, READ_O pulse (one cycle after a read pop)
// Configuration macro RV_BUFFERED_IF_STATUS_EN adds WRITE_LEVEL_O,
// READ_LEVEL_O and the sticky OVERFLOW_O (dropped CHANGE_I word).
// -----------------------------------------------------------------------------
module rv_buffered_interface
    import rv_buffered_if_pkg::*;
#(
    parameter int unsigned WRITE_WIDTH = 32'd8,
    parameter int unsigned READ_WIDTH  = 32'd8,
    parameter int unsigned WRITE_DEPTH = 32'd4,
    parameter int unsigned READ_DEPTH  = 32'd4
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    rv_buffered_interface_if.slave  bus
);
    logic                   wfull_s;
    logic                   wempty_s;
    logic [WRITE_WIDTH-1:0] whead_s;
    logic                   write_ready_s;
    logic                   wpush_s;
    logic                   wpop_s;

    logic                   rfull_s;
    logic                   rempty_s;
    logic [READ_WIDTH-1:0]  rhead_s;
    logic                   poll_s;
    logic                   capture_s;
    logic                   rpop_s;
    logic                   read_o_r;

    // Handshake glue for both directions.
    always_comb begin
        // Ready is held low during reset so nothing is accepted into a FIFO
        // that is being cleared.
        write_ready_s = ~RST_I & bus.WRITE_ENABLE_I & ~wfull_s;
        wpush_s       = bus.WRITE_VALID_I & write_ready_s;
        wpop_s        = ~wempty_s & bus.DEV_READY_I;
        // A poll only fetches when nothing is waiting, so one poll yields
        // exactly one word.
        poll_s        = bus.READ_ENABLE_I & bus.READ_READY_I & rempty_s;
        capture_s     = (bus.CHANGE_I | poll_s) & ~rfull_s;
        rpop_s        = ~rempty_s & bus.READ_READY_I;
    end

    rv_sync_fifo #(
        .WIDTH (WRITE_WIDTH),
        .DEPTH (WRITE_DEPTH)
    ) u_write_fifo (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .push_s      (wpush_s),
        .push_data_s (bus.WRITE_DATA_I),
        .pop_s       (wpop_s),
        .full_s      (wfull_s),
        .empty_s     (wempty_s),
        .head_s      (whead_s)
`ifdef RV_BUFFERED_IF_STATUS_EN
        ,
        .count_s     (bus.WRITE_LEVEL_O)
`endif
    );

    rv_sync_fifo #(
        .WIDTH (READ_WIDTH),
        .DEPTH (READ_DEPTH)
    ) u_read_fifo (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .push_s      (capture_s),
        .push_data_s (bus.DATA_I),
        .pop_s       (rpop_s),
        .full_s      (rfull_s),
        .empty_s     (rempty_s),
        .head_s      (rhead_s)
`ifdef RV_BUFFERED_IF_STATUS_EN
        ,
        .count_s     (bus.READ_LEVEL_O)
`endif
    );

    // One-cycle READ_O pulse following every read-FIFO pop.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            read_o_r <= 1'b0;
        end else begin
            read_o_r <= rpop_s;
        end
    end

`ifdef RV_BUFFERED_IF_STATUS_EN
    logic overflow_r;

    // Sticky overflow: a CHANGE_I word arrived while the read FIFO was full.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | (bus.CHANGE_I & rfull_s);
        end
    end

    // Drive the status flag onto the bus.
    always_comb begin
        bus.OVERFLOW_O = overflow_r;
    end
`endif

    // Drive the interface outputs.
    always_comb begin
        bus.WRITE_READY_O = write_ready_s;
        bus.UPDATE_O      = ~wempty_s;
        bus.DATA_O        = whead_s;
        bus.READ_VALID_O  = ~rempty_s;
        bus.READ_DATA_O   = rhead_s;
        bus.READ_O        = read_o_r;
    end

endmodule

// File: tb/tb_rv_buffered_interface.sv
// -----------------------------------------------------------------------------
// tb_rv_buffered_interface
// Queue-based reference model of both FIFOs, compared against the DUT on every
// falling clock edge, plus directed sequences with literal expectations.
// -----------------------------------------------------------------------------
module tb_rv_buffered_interface;
    localparam int WD = 4;
    localparam int RD = 4;

    logic CLK_I = 1'b0;
    logic RST_I = 1'b1;

    int checks   = 0;
    int failures = 0;

    rv_buffered_interface_if #(
        .WRITE_WIDTH (8),
        .READ_WIDTH  (8)
`ifdef RV_BUFFERED_IF_STATUS_EN
        ,
        .WRITE_DEPTH (WD),
        .READ_DEPTH  (RD)
`endif
    ) bus ();

    rv_buffered_interface #(
        .WRITE_WIDTH (8),
        .READ_WIDTH  (8),
        .WRITE_DEPTH (WD),
        .READ_DEPTH  (RD)
    ) dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .bus   (bus)
    );

    always #5 CLK_I = ~CLK_I;

    // Reference model state
    logic [7:0] wq[$];
    logic [7:0] rq[$];
    logic       exp_read_o = 1'b0;
    logic       exp_ovf    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on each clock edge, cleared by reset.
    always @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wq.delete();
            rq.delete();
            exp_read_o = 1'b0;
            exp_ovf    = 1'b0;
        end else begin
            bit wpush, wpop, poll, cap, rpop;
            wpush = bus.WRITE_VALID_I && bus.WRITE_ENABLE_I && (wq.size() < WD);
            wpop  = (wq.size() != 0) && bus.DEV_READY_I;
            poll  = bus.READ_ENABLE_I && bus.READ_READY_I && (rq.size() == 0);
            cap   = (bus.CHANGE_I || poll) && (rq.size() < RD);
            rpop  = (rq.size() != 0) && bus.READ_READY_I;
            if (bus.CHANGE_I && rq.size() == RD) exp_ovf = 1'b1;
            exp_read_o = rpop;
            if (wpop) void'(wq.pop_front());
            if (wpush) wq.push_back(bus.WRITE_DATA_I);
            if (rpop) void'(rq.pop_front());
            if (cap) rq.push_back(bus.DATA_I);
        end
    end

    // Compare process: every falling edge.
    always @(negedge CLK_I) begin
        chk("write_ready", {31'd0, bus.WRITE_READY_O},
            {31'd0, (!RST_I && bus.WRITE_ENABLE_I && wq.size() < WD)});
        chk("update", {31'd0, bus.UPDATE_O}, {31'd0, (wq.size() != 0)});
        if (wq.size() != 0) chk("data_o", {24'd0, bus.DATA_O}, {24'd0, wq[0]});
        chk("read_valid", {31'd0, bus.READ_VALID_O}, {31'd0, (rq.size() != 0)});
        if (rq.size() != 0) chk("read_data", {24'd0, bus.READ_DATA_O}, {24'd0, rq[0]});
        chk("read_o", {31'd0, bus.READ_O}, {31'd0, exp_read_o});
`ifdef RV_BUFFERED_IF_STATUS_EN
        chk("write_level", 32'(bus.WRITE_LEVEL_O), 32'(wq.size()));
        chk("read_level", 32'(bus.READ_LEVEL_O), 32'(rq.size()));
        chk("overflow", {31'd0, bus.OVERFLOW_O}, {31'd0, exp_ovf});
`endif
    end

    task automatic idle();
        bus.READ_READY_I   = 1'b0;
        bus.WRITE_VALID_I  = 1'b0;
        bus.WRITE_DATA_I   = 8'h00;
        bus.READ_ENABLE_I  = 1'b0;
        bus.WRITE_ENABLE_I = 1'b0;
        bus.DEV_READY_I    = 1'b0;
        bus.CHANGE_I       = 1'b0;
        bus.DATA_I         = 8'h00;
    endtask

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    initial begin
        idle();
        bus.WRITE_ENABLE_I = 1'b1;
        repeat (2) @(posedge CLK_I);
        @(negedge CLK_I);
        chk("rst_write_ready", {31'd0, bus.WRITE_READY_O}, 32'd0);
        chk("rst_update", {31'd0, bus.UPDATE_O}, 32'd0);
        chk("rst_read_valid", {31'd0, bus.READ_VALID_O}, 32'd0);
        chk("rst_read_o", {31'd0, bus.READ_O}, 32'd0);
        chk("rst_data_o", {24'd0, bus.DATA_O}, 32'd0);
        chk("rst_read_data", {24'd0, bus.READ_DATA_O}, 32'd0);
        step();
        RST_I = 1'b0;

        // Write FIFO fill: four accepted, fifth refused; then drain in order.
        bus.WRITE_VALID_I = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.WRITE_DATA_I = 8'(8'h11 * (k + 1));
            @(negedge CLK_I);
            chk("t1_ready", {31'd0, bus.WRITE_READY_O}, (k < 4) ? 32'd1 : 32'd0);
            step();
        end
        bus.WRITE_VALID_I = 1'b0;
        bus.DEV_READY_I   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK_I);
            chk("t1_data", {24'd0, bus.DATA_O}, 32'(8'h11 * (k + 1)));
            step();
        end
        @(negedge CLK_I);
        chk("t1_empty", {31'd0, bus.UPDATE_O}, 32'd0);
        step();
        bus.DEV_READY_I = 1'b0;

        // Full write FIFO with simultaneous pop and push: push refused.
        bus.WRITE_VALID_I = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.WRITE_DATA_I = 8'(k + 1);
            step();
        end
        bus.WRITE_DATA_I = 8'h66;
        bus.DEV_READY_I  = 1'b1;
        @(negedge CLK_I);
        chk("t5_ready_full", {31'd0, bus.WRITE_READY_O}, 32'd0);
        chk("t5_head", {24'd0, bus.DATA_O}, 32'h01);
        step();
        bus.WRITE_VALID_I = 1'b0;
        bus.DEV_READY_I   = 1'b0;
        @(negedge CLK_I);
        chk("t5_ready_after", {31'd0, bus.WRITE_READY_O}, 32'd1);
        chk("t5_head_after", {24'd0, bus.DATA_O}, 32'h02);
`ifdef RV_BUFFERED_IF_STATUS_EN
        chk("t5_level", 32'(bus.WRITE_LEVEL_O), 32'd3);
`endif
        step();
        bus.DEV_READY_I = 1'b1;
        repeat (3) step();
        bus.DEV_READY_I = 1'b0;
        @(negedge CLK_I);
        chk("t5_drained", {31'd0, bus.UPDATE_O}, 32'd0);
        step();

        // CHANGE_I captures and ordered read-out with READ_O pulses.
        bus.CHANGE_I = 1'b1;
        bus.DATA_I   = 8'hA1;
        step();
        bus.DATA_I   = 8'hA2;
        step();
        bus.CHANGE_I = 1'b0;
        @(negedge CLK_I);
        chk("t2_valid", {31'd0, bus.READ_VALID_O}, 32'd1);
        chk("t2_head", {24'd0, bus.READ_DATA_O}, 32'hA1);
        step();
        bus.READ_READY_I = 1'b1;
        @(negedge CLK_I);
        chk("t2_first", {24'd0, bus.READ_DATA_O}, 32'hA1);
        chk("t2_read_o0", {31'd0, bus.READ_O}, 32'd0);
        step();
        @(negedge CLK_I);
        chk("t2_second", {24'd0, bus.READ_DATA_O}, 32'hA2);
        chk("t2_read_o1", {31'd0, bus.READ_O}, 32'd1);
        step();
        @(negedge CLK_I);
        chk("t2_read_o2", {31'd0, bus.READ_O}, 32'd1);
        chk("t2_empty", {31'd0, bus.READ_VALID_O}, 32'd0);
        step();
        bus.READ_READY_I = 1'b0;
        @(negedge CLK_I);
        chk("t2_read_o3", {31'd0, bus.READ_O}, 32'd0);
        step();

        // Read FIFO overflow: the fifth word is dropped.
        bus.CHANGE_I = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.DATA_I = 8'(8'hB0 + k);
            step();
        end
        bus.DATA_I = 8'hEE;
        step();
        bus.CHANGE_I = 1'b0;
        @(negedge CLK_I);
        chk("t3_head", {24'd0, bus.READ_DATA_O}, 32'hB0);
`ifdef RV_BUFFERED_IF_STATUS_EN
        chk("t3_overflow", {31'd0, bus.OVERFLOW_O}, 32'd1);
        chk("t3_level", 32'(bus.READ_LEVEL_O), 32'd4);
`endif
        step();
        bus.READ_READY_I = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK_I);
            chk("t3_drain", {24'd0, bus.READ_DATA_O}, 32'(8'hB0 + k));
            step();
        end
        bus.READ_READY_I = 1'b0;
        @(negedge CLK_I);
        chk("t3_empty", {31'd0, bus.READ_VALID_O}, 32'd0);
`ifdef RV_BUFFERED_IF_STATUS_EN
        chk("t3_sticky", {31'd0, bus.OVERFLOW_O}, 32'd1);
`endif
        step();

        // Polled read: exactly one capture while the word is pending.
        bus.READ_ENABLE_I = 1'b1;
        bus.READ_READY_I  = 1'b1;
        bus.DATA_I        = 8'h5A;
        @(negedge CLK_I);
        chk("t4_not_yet", {31'd0, bus.READ_VALID_O}, 32'd0);
        step();
        @(negedge CLK_I);
        chk("t4_valid", {31'd0, bus.READ_VALID_O}, 32'd1);
        chk("t4_data", {24'd0, bus.READ_DATA_O}, 32'h5A);
        step();
        bus.READ_ENABLE_I = 1'b0;
        @(negedge CLK_I);
        chk("t4_no_second", {31'd0, bus.READ_VALID_O}, 32'd0);
        chk("t4_read_o", {31'd0, bus.READ_O}, 32'd1);
        step();
        bus.READ_READY_I = 1'b0;

        // Asynchronous reset with words buffered.
        bus.WRITE_VALID_I = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.WRITE_DATA_I = 8'(8'hC0 + k);
            bus.CHANGE_I     = (k == 0);
            bus.DATA_I       = 8'h77;
            step();
        end
        bus.WRITE_VALID_I = 1'b0;
        bus.CHANGE_I      = 1'b0;
        @(posedge CLK_I);
        #3;
        RST_I = 1'b1;
        #1;
        chk("t6_update", {31'd0, bus.UPDATE_O}, 32'd0);
        chk("t6_read_valid", {31'd0, bus.READ_VALID_O}, 32'd0);
        chk("t6_write_ready", {31'd0, bus.WRITE_READY_O}, 32'd0);
        @(posedge CLK_I);
        #3;
        RST_I = 1'b0;
        @(negedge CLK_I);
        chk("t6_after_update", {31'd0, bus.UPDATE_O}, 32'd0);
`ifdef RV_BUFFERED_IF_STATUS_EN
        chk("t6_wlevel", 32'(bus.WRITE_LEVEL_O), 32'd0);
        chk("t6_rlevel", 32'(bus.READ_LEVEL_O), 32'd0);
        chk("t6_overflow", {31'd0, bus.OVERFLOW_O}, 32'd0);
`endif
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bus.WRITE_VALID_I  = 1'($urandom_range(0, 1));
            bus.WRITE_DATA_I   = 8'($urandom);
            bus.WRITE_ENABLE_I = ($urandom_range(0, 3) != 0);
            bus.DEV_READY_I    = 1'($urandom_range(0, 1));
            bus.CHANGE_I       = ($urandom_range(0, 2) == 0);
            bus.DATA_I         = 8'($urandom);
            bus.READ_ENABLE_I  = 1'($urandom_range(0, 1));
            bus.READ_READY_I   = 1'($urandom_range(0, 1));
            step();
        end
        idle();
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
